disparity_search_ctrl: RTL and testbench



---
 rtl/disparity_search_ctrl_if.sv | 49 ++++
 rtl/disparity_search_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_disparity_search_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/disparity_search_ctrl_if.sv
// rtl/disparity_search_ctrl_if.sv - handshake/bus bundle for disparity_search_ctrl
// Purpose: groups the start/result, line-buffer fetch and MAC engine signals.
// Ports (master = search controller, slave = surrounding datapath):
//   start_in, busy_out, done_out, disparity_out, cost_out    : search control/result
//   fetch_req_out, fetch_row_out, fetch_disp_out             : row-pair request
//   fetch_valid_in, left_row_in, right_row_in                : row-pair response
//   mac_valid_out, mac_left_out, mac_right_out               : MAC issue
//   mac_acc_in, mac_valid_in                                 : MAC result
interface disparity_search_ctrl_if #(
  parameter int WIN_ROWS = 6,
  parameter int MAX_DISP = 64,
  parameter int ACC_W    = 20,
  parameter int COST_W   = 23
);
  // Width guards keep 1-entry configurations at a legal 1-bit index
  localparam int ROW_W  = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam int DISP_W = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;

  logic              start_in;
  logic              busy_out;
  logic              done_out;
  logic [DISP_W-1:0] disparity_out;
  logic [COST_W-1:0] cost_out;
  logic              fetch_req_out;
  logic [ROW_W-1:0]  fetch_row_out;
  logic [DISP_W-1:0] fetch_disp_out;
  logic              fetch_valid_in;
  logic [47:0]       left_row_in;
  logic [47:0]       right_row_in;
  logic              mac_valid_out;
  logic [47:0]       mac_left_out;
  logic [47:0]       mac_right_out;
  logic [ACC_W-1:0]  mac_acc_in;
  logic              mac_valid_in;

  modport master (
    input  start_in, fetch_valid_in, left_row_in, right_row_in, mac_acc_in, mac_valid_in,
    output busy_out, done_out, disparity_out, cost_out,
    output fetch_req_out, fetch_row_out, fetch_disp_out,
    output mac_valid_out, mac_left_out, mac_right_out
  );

  modport slave (
    output start_in, fetch_valid_in, left_row_in, right_row_in, mac_acc_in, mac_valid_in,
    input  busy_out, done_out, disparity_out, cost_out,
    input  fetch_req_out, fetch_row_out, fetch_disp_out,
    input  mac_valid_out, mac_left_out, mac_right_out
  );
endinterface

// File: rtl/disparity_search_ctrl.sv
// rtl/disparity_search_ctrl.sv - SSD window disparity search sequencer
// Purpose: for each disparity 0..MAX_DISP-1 fetches WIN_ROWS row pairs, feeds them one at a
//   time to the 6-pixel SSD MAC, sums the row costs and keeps the lowest-cost disparity.
// Ports: clk_in (clock), rst_in (async active-high reset), bus (disparity_search_ctrl_if.master:
//   start/busy/done/result, fetch request/response, MAC issue/result).
// Optional feature macro: DISP_EARLY_TERM_EN (abandon a disparity once its partial sum
//   already reaches the best cost; result unchanged, fewer fetches).
module disparity_search_ctrl #(
  parameter int WIN_ROWS = 6,
  parameter int MAX_DISP = 64,
  parameter int ACC_W    = 20,
  parameter int COST_W   = 23
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  disparity_search_ctrl_if.master bus
);
  localparam int ROW_W  = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam int DISP_W = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(WIN_ROWS - 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(MAX_DISP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_WAIT_MAC, S_CMP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [COST_W-1:0] sum_q, sum_d;
  logic [COST_W-1:0] best_q, best_d;
  logic [DISP_W-1:0] bestd_q, bestd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DISP_W-1:0] disparity_q, disparity_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic              fetch_req_q, fetch_req_d;
  logic              mac_valid_q, mac_valid_d;
  logic [47:0]       mac_left_q, mac_left_d;
  logic [47:0]       mac_right_q, mac_right_d;

  logic [COST_W-1:0] sum_next;
  logic              win;
  logic              et_skip;

  always_comb begin
    sum_next = sum_q + COST_W'(bus.mac_acc_in);
    // disp 0 always seeds best; afterwards strict < keeps the lowest disparity on ties
    win      = (sum_q < best_q) || (disp_q == '0);
`ifdef DISP_EARLY_TERM_EN
    // A partial sum already >= best can never win, so the remaining rows are pointless
    et_skip  = (disp_q != '0) && (sum_next >= best_q);
`else
    et_skip  = 1'b0;
`endif

    state_d     = state_q;
    row_d       = row_q;
    disp_d      = disp_q;
    sum_d       = sum_q;
    best_d      = best_q;
    bestd_d     = bestd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    disparity_d = disparity_q;
    cost_d      = cost_q;
    fetch_req_d = 1'b0;
    mac_valid_d = 1'b0;
    mac_left_d  = mac_left_q;
    mac_right_d = mac_right_q;

    // Pulse outputs are set on the transition so they are high while in the target state
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          state_d     = S_REQ;
          row_d       = '0;
          disp_d      = '0;
          sum_d       = '0;
          best_d      = '1;
          busy_d      = 1'b1;
          fetch_req_d = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (bus.fetch_valid_in) begin
          mac_left_d  = bus.left_row_in;
          mac_right_d = bus.right_row_in;
          mac_valid_d = 1'b1;
          state_d     = S_WAIT_MAC;
        end
      end
      S_WAIT_MAC: begin
        if (bus.mac_valid_in) begin
          sum_d = sum_next;
          if (et_skip || row_q == ROW_LAST) begin
            state_d = S_CMP;
          end else begin
            row_d       = row_q + ROW_W'(1);
            state_d     = S_REQ;
            fetch_req_d = 1'b1;
          end
        end
      end
      S_CMP: begin
        if (win) begin
          best_d  = sum_q;
          bestd_d = disp_q;
        end
        if (disp_q != DISP_LAST) begin
          disp_d      = disp_q + DISP_W'(1);
          row_d       = '0;
          sum_d       = '0;
          state_d     = S_REQ;
          fetch_req_d = 1'b1;
        end else begin
          // Result is published together with the done pulse, including this last compare
          state_d     = S_DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          disparity_d = win ? disp_q : bestd_q;
          cost_d      = win ? sum_q : best_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      disp_q      <= '0;
      sum_q       <= '0;
      best_q      <= '0;
      bestd_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      disparity_q <= '0;
      cost_q      <= '0;
      fetch_req_q <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_left_q  <= '0;
      mac_right_q <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      disp_q      <= disp_d;
      sum_q       <= sum_d;
      best_q      <= best_d;
      bestd_q     <= bestd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      disparity_q <= disparity_d;
      cost_q      <= cost_d;
      fetch_req_q <= fetch_req_d;
      mac_valid_q <= mac_valid_d;
      mac_left_q  <= mac_left_d;
      mac_right_q <= mac_right_d;
    end
  end

  assign bus.busy_out       = busy_q;
  assign bus.done_out       = done_q;
  assign bus.disparity_out  = disparity_q;
  assign bus.cost_out       = cost_q;
  assign bus.fetch_req_out  = fetch_req_q;
  assign bus.fetch_row_out  = row_q;
  assign bus.fetch_disp_out = disp_q;
  assign bus.mac_valid_out  = mac_valid_q;
  assign bus.mac_left_out   = mac_left_q;
  assign bus.mac_right_out  = mac_right_q;
endmodule

// File: tb/tb_disparity_search_ctrl.sv
// tb/tb_disparity_search_ctrl.sv - directed table-driven bench for disparity_search_ctrl
module tb_disparity_search_ctrl;
  localparam int WIN_ROWS = 6;
  localparam int MAX_DISP = 4;
  localparam int ACC_W    = 20;
  localparam int COST_W   = 23;
  localparam int NVEC     = 7;

  typedef logic [MAX_DISP-1:0][47:0] dif_t;
  typedef struct {
    dif_t dif;        // per-disparity per-pixel |left-right|
    int   lat;        // fetch latency in cycles
    int   exp_disp;
    int   exp_cost;
    int   fetch_full; // fetch count, full search
    int   fetch_et;   // fetch count with early termination
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disparity_search_ctrl_if #(.WIN_ROWS(WIN_ROWS), .MAX_DISP(MAX_DISP), .ACC_W(ACC_W), .COST_W(COST_W)) bus ();
  disparity_search_ctrl #(.WIN_ROWS(WIN_ROWS), .MAX_DISP(MAX_DISP), .ACC_W(ACC_W), .COST_W(COST_W)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.master)
  );

  int   checks = 0;
  int   failures = 0;
  vec_t vecs [NVEC];
  dif_t cur_dif;
  int   cur_lat = 1;
  int   fetch_cnt = 0;
  int   order_err = 0;
  bit   first_fetch = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [47:0] allpx(input logic [7:0] d);
    return {6{d}};
  endfunction

  function automatic dif_t difs(input logic [47:0] d0, input logic [47:0] d1,
                                input logic [47:0] d2, input logic [47:0] d3);
    dif_t t;
    t[0] = d0; t[1] = d1; t[2] = d2; t[3] = d3;
    return t;
  endfunction

  // Row data: odd rows subtract the difference, so the MAC must square signed diffs
  task automatic make_rows(input int r, input int d, output logic [47:0] l, output logic [47:0] rr);
    int lv, dv;
    for (int p = 0; p < 6; p++) begin
      lv = 60 + 11 * p + 5 * r + 3 * d;
      dv = int'(cur_dif[d][8*p +: 8]);
      l[8*p +: 8]  = 8'(lv);
      rr[8*p +: 8] = 8'((r % 2 == 1) ? lv - dv : lv + dv);
    end
  endtask

  // Line-buffer model: answers each request after cur_lat cycles, tracks request order
  initial begin
    int r, d;
    logic [47:0] l, rr;
    bus.fetch_valid_in = 1'b0;
    bus.left_row_in    = '0;
    bus.right_row_in   = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.fetch_req_out && !rst) begin
        r = int'(bus.fetch_row_out);
        d = int'(bus.fetch_disp_out);
        fetch_cnt++;
        if (first_fetch) begin
          if (!(r == 0 && d == 0)) order_err++;
        end
        first_fetch = 1'b0;
        make_rows(r, d, l, rr);
        repeat (cur_lat) @(posedge clk);
        #1;
        bus.left_row_in    = l;
        bus.right_row_in   = rr;
        bus.fetch_valid_in = 1'b1;
        @(posedge clk); #1;
        bus.fetch_valid_in = 1'b0;
      end
    end
  end

  // Request order: next row of the same disparity, or row 0 of the next disparity
  initial begin
    int pr, pd, r, d;
    pr = 0; pd = 0;
    forever begin
      @(posedge clk); #2;
      if (bus.fetch_req_out && !rst && fetch_cnt > 1) begin
        r = int'(bus.fetch_row_out);
        d = int'(bus.fetch_disp_out);
        if (d == pd) begin
          if (r != pr + 1) order_err++;
        end else if (!(r == 0 && d == pd + 1)) begin
          order_err++;
        end
      end
      if (bus.fetch_req_out) begin
        pr = int'(bus.fetch_row_out);
        pd = int'(bus.fetch_disp_out);
      end
    end
  end

  // SSD MAC model: result appears 3 cycles after mac_valid_out
  initial begin
    int acc, df;
    bus.mac_valid_in = 1'b0;
    bus.mac_acc_in   = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mac_valid_out) begin
        acc = 0;
        for (int p = 0; p < 6; p++) begin
          df  = int'(bus.mac_left_out[8*p +: 8]) - int'(bus.mac_right_out[8*p +: 8]);
          acc = acc + df * df;
        end
        repeat (3) @(posedge clk);
        #1;
        bus.mac_acc_in   = ACC_W'(acc);
        bus.mac_valid_in = 1'b1;
        @(posedge clk); #1;
        bus.mac_valid_in = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  task automatic run_vec(input int i, input bit poke);
    bit got;
    int exp_f;
    cur_dif     = vecs[i].dif;
    cur_lat     = vecs[i].lat;
    fetch_cnt   = 0;
    order_err   = 0;
    first_fetch = 1'b1;
`ifdef DISP_EARLY_TERM_EN
    exp_f = vecs[i].fetch_et;
`else
    exp_f = vecs[i].fetch_full;
`endif
    pulse_start();
    check($sformatf("v%0d_busy_after_start", i), bus.busy_out, 1);
    got = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      bus.start_in = (poke && n == 10);
      @(posedge clk); #1;
      if (bus.done_out) got = 1'b1;
    end
    bus.start_in = 1'b0;
    check($sformatf("v%0d_done_seen", i), got, 1);
    check($sformatf("v%0d_disparity", i), bus.disparity_out, vecs[i].exp_disp);
    check($sformatf("v%0d_cost", i), bus.cost_out, vecs[i].exp_cost);
    check($sformatf("v%0d_fetch_count", i), fetch_cnt, exp_f);
    check($sformatf("v%0d_fetch_order_errors", i), order_err, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_one_cycle", i), bus.done_out, 0);
    check($sformatf("v%0d_idle_after_done", i), bus.busy_out, 0);
    check($sformatf("v%0d_result_held", i), bus.cost_out, vecs[i].exp_cost);
  endtask

  initial begin
    bit got;
    int stray;
    localparam logic [47:0] P700 = {8'd20, 8'd10, 8'd10, 8'd10, 8'd0, 8'd0};

    //                 disp0      disp1      disp2      disp3     lat  disp cost  full  et
    vecs[0] = '{difs(allpx(0),  allpx(0),  allpx(0),  allpx(0)),  1,   0,   0,    24,   9};
    vecs[1] = '{difs(allpx(10), allpx(10), allpx(0),  allpx(10)), 3,   2,   0,    24,  19};
    vecs[2] = '{difs(allpx(10), allpx(10), P700,      P700),      2,   0,   3600, 24,  24};
    vecs[3] = '{difs(allpx(10), allpx(10), allpx(0),  allpx(10)), 7,   2,   0,    24,  19};
    vecs[4] = '{difs(allpx(0),  allpx(1),  allpx(1),  allpx(1)),  1,   0,   0,    24,   9};
    vecs[5] = '{difs(allpx(4),  allpx(3),  allpx(2),  allpx(1)),  4,   3,   36,   24,  24};
    vecs[6] = '{difs(allpx(5),  allpx(3),  allpx(3),  allpx(4)),  1,   1,   324,  24,  22};

    bus.start_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy_out, 0);
    check("reset_done", bus.done_out, 0);
    check("reset_fetch_req", bus.fetch_req_out, 0);
    check("reset_mac_valid", bus.mac_valid_out, 0);
    check("reset_disparity", bus.disparity_out, 0);
    check("reset_cost", bus.cost_out, 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i, 1'b0);

    // Reset while waiting on the MAC for disparity 3
    cur_dif = vecs[5].dif; cur_lat = vecs[5].lat; first_fetch = 1'b1; fetch_cnt = 0;
    pulse_start();
    got = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(posedge clk); #1;
      if (bus.mac_valid_out && bus.fetch_disp_out == 2'd3) got = 1'b1;
    end
    check("rst_reach_wait_mac_d3", got, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy_out, 0);
    check("rst_mid_done", bus.done_out, 0);
    check("rst_mid_mac_valid", bus.mac_valid_out, 0);
    check("rst_mid_mac_left", bus.mac_left_out, 0);
    check("rst_mid_disparity", bus.disparity_out, 0);
    check("rst_mid_cost", bus.cost_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stray = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.done_out || bus.busy_out || bus.fetch_req_out) stray++;
    end
    check("rst_no_stale_activity", stray, 0);
    run_vec(5, 1'b0);

    // start_in while busy must not restart the search
    run_vec(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
